// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq_ctrl
//  Description : Sequencer for the unsigned 32x32 -> 64-bit MULTU operation.
//                Performs a shift-and-add multiply over WIDTH iterations,
//                borrowing the ALU's shared adder through the add_* port.
//
//  Ports       : clk, rst_n         - clock and asynchronous active-low reset
//                start, mcand,      - request and operands, sampled only
//                mplier               while idle
//                busy               - high while iterating
//                done               - one-cycle pulse once product is final
//                product            - {HI,LO}, held until the next start
//                add_a, add_b,      - drive to the shared adder
//                add_cin
//                add_sum, add_cout  - combinational result from the adder
//
//  Revision    : 1.0  initial release
// ============================================================================
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    localparam logic [0:0]       c_ST_IDLE = 1'b0;
    localparam logic [0:0]       c_ST_CALC = 1'b1;
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mcand;
    logic [CNT_W-1:0] r_count;
    logic             r_done;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_mcand_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_done_nxt;
    logic             w_busy;

    // Adder drive is kept out of the FSM block so the path
    // add_a/add_b -> external adder -> add_sum never looks like a loop
    // through a single process. Outside CALC add_b is forced to zero so the
    // adder always sees defined operands.
    assign add_a   = r_hi;
    assign add_b   = ((r_state == c_ST_CALC) && r_lo[0]) ? r_mcand : '0;
    assign add_cin = 1'b0;

    assign busy    = w_busy;
    assign done    = r_done;
    assign product = {r_hi, r_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_mcand <= w_mcand_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_mcand_nxt = r_mcand;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        w_busy      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_hi_nxt    = '0;
                    w_lo_nxt    = mplier;
                    w_mcand_nxt = mcand;
                    w_count_nxt = '0;
                    w_state_nxt = c_ST_CALC;
                end
            end

            c_ST_CALC: begin
                w_busy = 1'b1;
                // 65-bit right shift of {cout, sum, lo}: the adder carry lands
                // in hi[MSB], so the full 64-bit result is exact.
                w_hi_nxt    = {add_cout, add_sum[WIDTH-1:1]};
                w_lo_nxt    = {add_sum[0], r_lo[WIDTH-1:1]};
                w_count_nxt = r_count + c_ONE;
                if (r_count == c_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_seq_ctrl
//  Description : Self-checking bench for mult_seq_ctrl. Models the shared
//                adder, keeps a scoreboard of expected products and due
//                cycles, and runs one task per scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    mult_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mcand    (mcand),
        .mplier   (mplier),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Shared ALU adder model
    logic [32:0] w_add;
    assign w_add    = 33'(add_a) + 33'(add_b) + 33'(add_cin);
    assign add_sum  = w_add[31:0];
    assign add_cout = w_add[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every done pulse must match the oldest outstanding
    // multiply, both in value and in the cycle it appears.
    always @(negedge clk) begin
        if (rst_n && done) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: done=1 with nothing outstanding at cycle %0d (required no done)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (product !== e.prod) begin
                    miscompares++;
                    $display("FAIL sb_product: got %h, expected %h", product, e.prod);
                end
                vectors++;
                if (cyc != e.due) begin
                    miscompares++;
                    $display("FAIL sb_latency: done at cycle %0d, expected cycle %0d", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one request at a negedge; it is accepted at the following edge.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sb.push_back('{prod: 64'(a) * 64'(b), due: cyc + 32});
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk);
            #2;
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding after %0d cycles, expected 0", sb.size(), limit);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mcand = '0;
        mplier = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy=%b done=%b, expected 0 0", busy, done);
        end
        vectors++;
        if (product !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_product: got %h, expected 0", product);
        end
        vectors++;
        if (add_a !== 32'h0 || add_b !== 32'h0 || add_cin !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_adder: a=%h b=%h cin=%b, expected 0 0 0", add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_start(32'd3, 32'd5, 1'b1);
        for (int k = 1; k < 32; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0 || add_cin !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_busy: step %0d busy=%b done=%b cin=%b, expected 1 0 0", k, busy, done, add_cin);
            end
            vectors++;
            if (add_a !== product[63:32]) begin
                miscompares++;
                $display("FAIL basic_add_a: step %0d add_a=%h, expected hi=%h", k, add_a, product[63:32]);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || product !== 64'h0000_0000_0000_000F) begin
            miscompares++;
            $display("FAIL basic_done: done=%b busy=%b product=%h, expected 1 0 000000000000000f", done, busy, product);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || product !== 64'h0000_0000_0000_000F || add_b !== 32'h0) begin
            miscompares++;
            $display("FAIL basic_after: done=%b product=%h add_b=%h, expected 0 000000000000000f 0", done, product, add_b);
        end
    endtask

    task automatic test_corners();
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_drain(60);
        vectors++;
        if (product !== 64'hFFFF_FFFE_0000_0001) begin
            miscompares++;
            $display("FAIL max_operands: got %h, expected fffffffe00000001", product);
        end
        do_start(32'h8000_0000, 32'd2, 1'b1);
        wait_drain(60);
        vectors++;
        if (product !== 64'h0000_0001_0000_0000) begin
            miscompares++;
            $display("FAIL msb_times_two: got %h, expected 0000000100000000", product);
        end
        do_start(32'd0, 32'h1234_5678, 1'b1);
        wait_drain(60);
        vectors++;
        if (product !== 64'h0) begin
            miscompares++;
            $display("FAIL zero_mcand: got %h, expected 0", product);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            do_start(a, b, 1'b1);
            wait_drain(60);
        end
    endtask

    task automatic test_ignore_start();
        do_start(32'd7, 32'd6, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start  = 1'b1;
        mcand  = 32'd9;
        mplier = 32'd9;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_busy: busy=%b, expected 1", busy);
        end
        wait_drain(60);
        vectors++;
        if (product !== 64'd42) begin
            miscompares++;
            $display("FAIL ignore_product: got %h, expected 000000000000002a", product);
        end
        repeat (40) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || product !== 64'd42) begin
            miscompares++;
            $display("FAIL ignore_queued: busy=%b product=%h, expected 0 000000000000002a", busy, product);
        end
    endtask

    task automatic test_reset_mid();
        do_start(32'd100, 32'd100, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'h0) begin
            miscompares++;
            $display("FAIL midreset_clear: busy=%b done=%b product=%h, expected 0 0 0", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || product !== 64'h0) begin
            miscompares++;
            $display("FAIL midreset_resume: busy=%b product=%h, expected 0 0", busy, product);
        end
        do_start(32'd2, 32'd3, 1'b1);
        wait_drain(60);
        vectors++;
        if (product !== 64'd6) begin
            miscompares++;
            $display("FAIL midreset_next: got %h, expected 0000000000000006", product);
        end
    endtask

    task automatic test_back_to_back();
        int  t_first;
        int  t_second;
        bit  seen;
        do_start(32'd11, 32'd13, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL b2b_first_timeout: no done within 40 cycles, expected done");
        end
        t_first = cyc;
        vectors++;
        if (product !== 64'd143) begin
            miscompares++;
            $display("FAIL b2b_first_product: got %h, expected 000000000000008f", product);
        end
        start  = 1'b1;
        mcand  = 32'd17;
        mplier = 32'd19;
        sb.push_back('{prod: 64'd323, due: cyc + 33});
        @(posedge clk);
        #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b done=%b, expected 1 0", busy, done);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        t_second = cyc;
        vectors++;
        if (!seen || (t_second - t_first) != 33) begin
            miscompares++;
            $display("FAIL b2b_spacing: seen=%b spacing=%0d, expected 1 33", seen, t_second - t_first);
        end
        vectors++;
        if (product !== 64'd323) begin
            miscompares++;
            $display("FAIL b2b_second_product: got %h, expected 0000000000000143", product);
        end
        wait_drain(10);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
